// File: rtl/store_marquee_if.sv
// Bus bundle for the store marquee.
// Ports carried:
//   upc       item code, sampled only while load is high
//   load      one-cycle strobe: latch upc and restart the display
//   scroll_en 1 = advance the window on each step, 0 = freeze it
//   alert     1 = blink the whole display
//   hex       active-low segments {g,f,e,d,c,b,a}, digit i at [7i+6:7i], digit 0 leftmost
//   wrap      one-cycle pulse when the window offset wraps to 0
//   loaded    high once an item has been loaded, until reset
// master drives the controls (host side), slave is the marquee itself.
interface store_marquee_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    logic [2:0]              upc;
    logic                    load;
    logic                    scroll_en;
    logic                    alert;
    logic [7*NUM_DIGITS-1:0] hex;
    logic                    wrap;
    logic                    loaded;

    modport master (
        output upc, load, scroll_en, alert,
        input  hex, wrap, loaded
    );

    modport slave (
        input  upc, load, scroll_en, alert,
        output hex, wrap, loaded
    );
endinterface

// File: rtl/store_marquee.sv
// Store marquee: scrolls a six-character item name across a row of
// active-low 7-segment digits, with an optional whole-display blink.
// Ports:
//   clk       single rising-edge clock
//   reset_n   synchronous active-low reset
//   bus       store_marquee_if.slave (upc/load/scroll_en/alert in,
//             hex/wrap/loaded out, all outputs registered)
module store_marquee #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned TICK_DIV   = 25000000
) (
    input  logic            clk,
    input  logic            reset_n,
    store_marquee_if.slave  bus
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OW = $clog2(MSG_LEN);
    localparam int unsigned HW = 7 * NUM_DIGITS;
    localparam int unsigned NAME_LEN = 6;

    // Glyphs, active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] G_C     = 7'b1000110;
    localparam logic [6:0] G_O     = 7'b1000000;
    localparam logic [6:0] G_F     = 7'b0001110;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_H     = 7'b0001001;
    localparam logic [6:0] G_U     = 7'b1000001;
    localparam logic [6:0] G_LB    = 7'b0000011;
    localparam logic [6:0] G_A     = 7'b0001000;
    localparam logic [6:0] G_P     = 7'b0001100;
    localparam logic [6:0] G_N     = 7'b1001000;
    localparam logic [6:0] G_LD    = 7'b0100001;
    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    // Item name table; element 0 is the first (leftmost) character.
    function automatic logic [NAME_LEN-1:0][6:0] name_row(input logic [2:0] code);
        logic [NAME_LEN-1:0][6:0] row;
        row = {G_DASH, G_DASH, G_DASH, G_DASH, G_DASH, G_DASH};
        case (code)
            3'b000:  row = {G_E,  G_E,     G_F,     G_F,  G_O,  G_C };
            3'b001:  row = {G_P,  G_A,     G_C,     G_LB, G_U,  G_H };
            3'b011:  row = {G_E,  G_L,     G_LD,    G_N,  G_A,  G_C };
            3'b100:  row = {G_LD, G_C,     G_BLANK, G_P,  G_O,  G_P };
            3'b101:  row = {G_BLANK, G_E,  G_N,     G_O,  G_H,  G_P };
            3'b110:  row = {G_N,  G_A,     G_P,     G_LD, G_E,  G_LB};
            default: row = {G_DASH, G_DASH, G_DASH, G_DASH, G_DASH, G_DASH};
        endcase
        return row;
    endfunction

    // Character at ring position pos; positions past the name are blank.
    function automatic logic [6:0] ring_char(input logic [2:0] code, input int unsigned pos);
        logic [NAME_LEN-1:0][6:0] row;
        logic [6:0]               g;
        row = name_row(code);
        g   = G_BLANK;
        if (pos < NAME_LEN) begin
            g = row[3'(pos)];
        end
        return g;
    endfunction

    state_t          r_state;
    logic [TW-1:0]   r_tick;
    logic [OW-1:0]   r_offset;
    logic            r_blink;
    logic [2:0]      r_upc;
    logic            r_wrap;
    logic            r_loaded;
    logic [HW-1:0]   r_hex;

    state_t          w_state_nxt;
    logic [TW-1:0]   w_tick_nxt;
    logic [OW-1:0]   w_offset_nxt;
    logic            w_blink_nxt;
    logic [2:0]      w_upc_nxt;
    logic            w_wrap_nxt;
    logic            w_loaded_nxt;
    logic [HW-1:0]   w_hex_nxt;
    logic            w_step;

    // A scroll step fires on the last count of the tick divider while an item is shown.
    assign w_step = (r_state != ST_BLANK) && (r_tick == TW'(TICK_DIV - 1));

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick;
        w_offset_nxt = r_offset;
        w_blink_nxt  = r_blink;
        w_upc_nxt    = r_upc;
        w_wrap_nxt   = 1'b0;
        w_loaded_nxt = r_loaded;
        w_hex_nxt    = '1;

        case (r_state)
            ST_BLANK: begin
                if (bus.load) begin
                    w_state_nxt = bus.scroll_en ? ST_SCROLL : ST_SHOW;
                end
            end
            ST_SHOW, ST_SCROLL: begin
                w_state_nxt = bus.scroll_en ? ST_SCROLL : ST_SHOW;
            end
            default: begin
                w_state_nxt = ST_BLANK;
            end
        endcase

        if (bus.load) begin
            // Load wins over a coincident step: no advance, no wrap.
            w_upc_nxt    = bus.upc;
            w_offset_nxt = '0;
            w_tick_nxt   = '0;
            w_blink_nxt  = 1'b0;
            w_loaded_nxt = 1'b1;
        end else begin
            if (r_state != ST_BLANK) begin
                w_tick_nxt = w_step ? '0 : r_tick + TW'(1);
            end
            if (w_step && (r_state == ST_SCROLL)) begin
                if (r_offset == OW'(MSG_LEN - 1)) begin
                    w_offset_nxt = '0;
                    w_wrap_nxt   = 1'b1;
                end else begin
                    w_offset_nxt = r_offset + OW'(1);
                end
            end
            if (!bus.alert) begin
                w_blink_nxt = 1'b0;
            end else if (w_step) begin
                w_blink_nxt = ~r_blink;
            end
        end

        // Display image follows the state being entered so hex lines up with offset/wrap.
        // blink can only be 1 while alert is held, so it alone selects the dark phase.
        if ((w_state_nxt != ST_BLANK) && !w_blink_nxt) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                int unsigned pos;
                pos = 32'(w_offset_nxt) + i;
                if (pos >= MSG_LEN) begin
                    pos = pos - MSG_LEN;
                end
                w_hex_nxt[7*i +: 7] = ring_char(w_upc_nxt, pos);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_BLANK;
            r_tick   <= '0;
            r_offset <= '0;
            r_blink  <= 1'b0;
            r_upc    <= 3'b000;
            r_wrap   <= 1'b0;
            r_loaded <= 1'b0;
            r_hex    <= '1;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_offset <= w_offset_nxt;
            r_blink  <= w_blink_nxt;
            r_upc    <= w_upc_nxt;
            r_wrap   <= w_wrap_nxt;
            r_loaded <= w_loaded_nxt;
            r_hex    <= w_hex_nxt;
        end
    end

    assign bus.hex    = r_hex;
    assign bus.wrap   = r_wrap;
    assign bus.loaded = r_loaded;

endmodule
